handshake_src_queue: RTL and testbench

- Source-side endpoint of a req/ack CDC link, entirely in the source clock domain.
- Accepts words over valid/ready into a DEPTH-entry FIFO and launches one transfer at a time over req_o/data_o.
- Synchronises the asynchronous ack_i internally; four-phase or two-phase (toggle) protocol is selected by parameter.
- Replaces the single-entry source FSM wherever the producer must not stall on every word.

---
 rtl/hs_pkg.sv | 15 +
 rtl/chain_synchronizer.sv | 23 ++
 rtl/handshake_src_queue.sv | 121 ++++++++++++
 tb/tb_handshake_src_queue.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared types for the req/ack handshake source endpoint.
package hs_pkg;

    typedef enum logic {
        HS_FOUR_PHASE = 1'b0,
        HS_TWO_PHASE  = 1'b1
    } hs_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_src_state_e;

endpackage

// File: rtl/chain_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module chain_synchronizer #(
    parameter int unsigned LENGTH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [LENGTH-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[LENGTH-2:0], d_i};
        end
    end

    assign q_o = chain_q[LENGTH-1];

endmodule

// File: rtl/handshake_src_queue.sv
// Source side of a req/ack CDC link: a small FIFO in front of a single-transfer
// handshake FSM, four-phase or two-phase by parameter.
module handshake_src_queue #(
    parameter int unsigned      DATA_WIDTH   = 32,
    parameter int unsigned      DEPTH        = 4,
    parameter int unsigned      CHAIN_LENGTH = 3,
    parameter hs_pkg::hs_mode_e MODE         = hs_pkg::HS_FOUR_PHASE
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         valid_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         ready_o,
    output logic                         req_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    input  logic                         ack_i,
    output logic                         busy_o,
    output logic                         idle_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    import hs_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] fifoMem_q [DEPTH];
    logic [PTR_W-1:0]      wrPtr_q;
    logic [PTR_W-1:0]      rdPtr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    hs_src_state_e         state_q;
    logic                  req_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ackSync;
    logic                  push;
    logic                  launch;

    chain_synchronizer #(
        .LENGTH(CHAIN_LENGTH)
    ) u_ackSync (
        .clk_i (clk_i),
        .rst_ni(~reset_i),
        .d_i   (ack_i),
        .q_o   (ackSync)
    );

    // Full/empty are judged from the registered count only, so a pop in the
    // same cycle never opens ready_o early.
    assign ready_o = (count_q != CNT_W'(DEPTH));
    assign push    = valid_i && ready_o;
    assign launch  = (state_q == IDLE) && (count_q != '0);
    assign count_d = count_q + CNT_W'(push) - CNT_W'(launch);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (launch) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Launch only from IDLE, so consecutive transfers are separated by one
    // IDLE cycle; a synchronised ack seen while IDLE is simply ignored.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        data_q  <= fifoMem_q[rdPtr_q];
                        req_q   <= (MODE == HS_TWO_PHASE) ? ~req_q : 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (MODE == HS_TWO_PHASE) begin
                        if (ackSync == req_q) begin
                            state_q <= IDLE;
                        end
                    end else if (ackSync) begin
                        req_q   <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ackSync) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_o   = req_q;
    assign data_o  = data_q;
    assign busy_o  = (state_q != IDLE);
    assign idle_o  = (state_q == IDLE) && (count_q == '0);
    assign count_o = count_q;

endmodule

// File: tb/tb_handshake_src_queue.sv
// Directed and randomised checks of handshake_src_queue in both protocol modes.
module tb_handshake_src_queue;

    import hs_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // Four-phase instance, DEPTH=4
    logic        valid4 = 1'b0, ready4, req4, ack4 = 1'b0, busy4, idle4;
    logic [31:0] dataIn4 = '0, data4;
    logic [2:0]  count4;

    // Two-phase instance, DEPTH=8
    logic        valid2 = 1'b0, ready2, req2, ack2 = 1'b0, busy2, idle2;
    logic [31:0] dataIn2 = '0, data2;
    logic [3:0]  count2;

    handshake_src_queue #(
        .DATA_WIDTH(32), .DEPTH(4), .CHAIN_LENGTH(3), .MODE(HS_FOUR_PHASE)
    ) dut4 (
        .clk_i(clk), .reset_i(reset), .valid_i(valid4), .data_i(dataIn4),
        .ready_o(ready4), .req_o(req4), .data_o(data4), .ack_i(ack4),
        .busy_o(busy4), .idle_o(idle4), .count_o(count4)
    );

    handshake_src_queue #(
        .DATA_WIDTH(32), .DEPTH(8), .CHAIN_LENGTH(3), .MODE(HS_TWO_PHASE)
    ) dut2 (
        .clk_i(clk), .reset_i(reset), .valid_i(valid2), .data_i(dataIn2),
        .ready_o(ready2), .req_o(req2), .data_o(data2), .ack_i(ack2),
        .busy_o(busy2), .idle_o(idle2), .count_o(count2)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] recv4[$];
    logic [31:0] recv2[$];
    logic [31:0] exp4[$];
    logic [31:0] exp2[$];
    bit          auto4 = 0, auto2 = 0;
    int          maxDly4 = 0, maxDly2 = 0, dly4 = 0, dly2 = 0;
    int          toggles2 = 0, idleRun2 = 0;
    int          gaps2[$];
    logic        prevReq2 = 1'b0, prevBusy2 = 1'b0, prevBusy4 = 1'b0;
    logic [31:0] prevData4 = '0, prevData2 = '0;

    // Destination models and data_o stability monitor, all sampled on negedge
    initial forever begin
        @(negedge clk);
        if (auto4) begin
            if (req4 && !ack4) begin
                if (dly4 == 0) begin
                    ack4 = 1'b1;
                    recv4.push_back(data4);
                    dly4 = $urandom_range(maxDly4, 0);
                end else dly4--;
            end else if (!req4 && ack4) begin
                if (dly4 == 0) begin
                    ack4 = 1'b0;
                    dly4 = $urandom_range(maxDly4, 0);
                end else dly4--;
            end
        end
        if (auto2 && (req2 !== ack2)) begin
            if (dly2 == 0) begin
                ack2 = req2;
                recv2.push_back(data2);
                dly2 = $urandom_range(maxDly2, 0);
            end else dly2--;
        end
        if (busy4 && prevBusy4) begin
            checks++;
            if (data4 !== prevData4) begin
                errors++;
                $display("[TB] FAIL stable_data4 got %h want %h", data4, prevData4);
            end
        end
        if (busy2 && prevBusy2) begin
            checks++;
            if (data2 !== prevData2) begin
                errors++;
                $display("[TB] FAIL stable_data2 got %h want %h", data2, prevData2);
            end
        end
        if (req2 !== prevReq2) toggles2++;
        if (!busy2) idleRun2++;
        else if (!prevBusy2) begin
            gaps2.push_back(idleRun2);
            idleRun2 = 0;
        end
        prevReq2  = req2;
        prevBusy4 = busy4;
        prevBusy2 = busy2;
        prevData4 = data4;
        prevData2 = data2;
    end

    task automatic doReset();
        reset  = 1'b1;
        valid4 = 1'b0; valid2 = 1'b0;
        auto4  = 0;    auto2  = 0;
        ack4   = 1'b0; ack2   = 1'b0;
        dly4   = 0;    dly2   = 0;
        repeat (3) @(negedge clk);
        recv4.delete(); recv2.delete(); exp4.delete(); exp2.delete(); gaps2.delete();
        toggles2 = 0; idleRun2 = 0; prevReq2 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Entered and left at a negedge; the word is taken at the posedge in between
    task automatic push4(input logic [31:0] w);
        int n = 0;
        dataIn4 = w;
        valid4  = 1'b1;
        while (!ready4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready4) begin
            checks++; errors++;
            $display("[TB] FAIL push4_timeout got ready=%b want 1", ready4);
        end
        @(negedge clk);
    endtask

    task automatic push2(input logic [31:0] w);
        int n = 0;
        dataIn2 = w;
        valid2  = 1'b1;
        while (!ready2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready2) begin
            checks++; errors++;
            $display("[TB] FAIL push2_timeout got ready=%b want 1", ready2);
        end
        @(negedge clk);
    endtask

    task automatic waitRecv4(input int n, input int limit);
        int c = 0;
        while (recv4.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (recv4.size() != n) begin
            errors++;
            $display("[TB] FAIL recv4_count got %0d want %0d", recv4.size(), n);
        end
    endtask

    task automatic waitRecv2(input int n, input int limit);
        int c = 0;
        while (recv2.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (recv2.size() != n) begin
            errors++;
            $display("[TB] FAIL recv2_count got %0d want %0d", recv2.size(), n);
        end
    endtask

    task automatic test_reset();
        doReset();
        checks += 8;
        if (ready4 !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b want 1", ready4); end
        if (req4 !== 1'b0)   begin errors++; $display("[TB] FAIL rst_req got %b want 0", req4); end
        if (data4 !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got %h want 0", data4); end
        if (busy4 !== 1'b0)  begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy4); end
        if (idle4 !== 1'b1)  begin errors++; $display("[TB] FAIL rst_idle got %b want 1", idle4); end
        if (count4 !== 3'd0) begin errors++; $display("[TB] FAIL rst_count got %0d want 0", count4); end
        if (req2 !== 1'b0)   begin errors++; $display("[TB] FAIL rst_req2 got %b want 0", req2); end
        if (count2 !== 4'd0) begin errors++; $display("[TB] FAIL rst_count2 got %0d want 0", count2); end
    endtask

    task automatic test_four_phase();
        doReset();
        push4(32'hA5A5_A5A5);
        valid4 = 1'b0;
        checks += 2;
        if (count4 !== 3'd1) begin errors++; $display("[TB] FAIL fp_count_e0 got %0d want 1", count4); end
        if (req4 !== 1'b0)   begin errors++; $display("[TB] FAIL fp_req_e0 got %b want 0", req4); end
        @(negedge clk);
        checks += 4;
        if (req4 !== 1'b1)          begin errors++; $display("[TB] FAIL fp_req_launch got %b want 1", req4); end
        if (data4 !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL fp_data_launch got %h want a5a5a5a5", data4); end
        if (busy4 !== 1'b1)         begin errors++; $display("[TB] FAIL fp_busy_launch got %b want 1", busy4); end
        if (count4 !== 3'd0)        begin errors++; $display("[TB] FAIL fp_count_launch got %0d want 0", count4); end
        ack4 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req4 !== 1'b1) begin errors++; $display("[TB] FAIL fp_req_hold got %b want 1", req4); end
        @(negedge clk);
        checks++;
        if (req4 !== 1'b0) begin errors++; $display("[TB] FAIL fp_req_fall got %b want 0", req4); end
        ack4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("[TB] FAIL fp_busy_release got %b want 1", busy4); end
        @(negedge clk);
        checks += 2;
        if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL fp_busy_done got %b want 0", busy4); end
        if (idle4 !== 1'b1) begin errors++; $display("[TB] FAIL fp_idle_done got %b want 1", idle4); end
    endtask

    task automatic test_fill();
        int c = 0;
        doReset();
        for (int i = 1; i <= 5; i++) push4(32'(i));
        checks += 4;
        if (count4 !== 3'd4)  begin errors++; $display("[TB] FAIL fill_count got %0d want 4", count4); end
        if (ready4 !== 1'b0)  begin errors++; $display("[TB] FAIL fill_ready got %b want 0", ready4); end
        if (req4 !== 1'b1)    begin errors++; $display("[TB] FAIL fill_req got %b want 1", req4); end
        if (data4 !== 32'd1)  begin errors++; $display("[TB] FAIL fill_data got %h want 1", data4); end
        dataIn4 = 32'd6;
        repeat (5) @(negedge clk);
        checks += 2;
        if (count4 !== 3'd4) begin errors++; $display("[TB] FAIL fill_held_count got %0d want 4", count4); end
        if (ready4 !== 1'b0) begin errors++; $display("[TB] FAIL fill_held_ready got %b want 0", ready4); end
        maxDly4 = 0; dly4 = 0; auto4 = 1;
        push4(32'd6);
        valid4 = 1'b0;
        waitRecv4(6, 500);
        for (int i = 0; i < recv4.size(); i++) begin
            checks++;
            if (recv4[i] !== 32'(i + 1)) begin
                errors++;
                $display("[TB] FAIL fill_order[%0d] got %h want %h", i, recv4[i], 32'(i + 1));
            end
        end
        while (!(idle4 && !ack4) && c < 200) begin @(negedge clk); c++; end
        auto4 = 0;
    endtask

    task automatic test_two_phase();
        int c = 0;
        doReset();
        maxDly2 = 0; dly2 = 0; auto2 = 1;
        for (int i = 0; i < 8; i++) push2(32'h0101_0101 * 32'(i) + 32'h7);
        valid2 = 1'b0;
        waitRecv2(8, 500);
        while (!idle2 && c < 100) begin @(negedge clk); c++; end
        checks += 3;
        if (toggles2 != 8)     begin errors++; $display("[TB] FAIL tp_toggles got %0d want 8", toggles2); end
        if (req2 !== 1'b0)     begin errors++; $display("[TB] FAIL tp_req_end got %b want 0", req2); end
        if (gaps2.size() != 8) begin errors++; $display("[TB] FAIL tp_launches got %0d want 8", gaps2.size()); end
        for (int i = 0; i < recv2.size(); i++) begin
            checks++;
            if (recv2[i] !== 32'h0101_0101 * 32'(i) + 32'h7) begin
                errors++;
                $display("[TB] FAIL tp_order[%0d] got %h want %h", i, recv2[i], 32'h0101_0101 * 32'(i) + 32'h7);
            end
        end
        for (int i = 1; i < gaps2.size(); i++) begin
            checks++;
            if (gaps2[i] != 1) begin errors++; $display("[TB] FAIL tp_gap[%0d] got %0d want 1", i, gaps2[i]); end
        end
        auto2 = 0;
    endtask

    task automatic test_back_to_back();
        int c = 0;
        doReset();
        maxDly4 = 0; dly4 = 0; auto4 = 1;
        push4(32'h100);
        push4(32'h101);
        checks += 3;
        if (count4 !== 3'd1)    begin errors++; $display("[TB] FAIL b2b_count got %0d want 1", count4); end
        if (req4 !== 1'b1)      begin errors++; $display("[TB] FAIL b2b_req got %b want 1", req4); end
        if (data4 !== 32'h100)  begin errors++; $display("[TB] FAIL b2b_data got %h want 100", data4); end
        for (int i = 2; i < 12; i++) push4(32'h100 + 32'(i));
        valid4 = 1'b0;
        waitRecv4(12, 2000);
        for (int i = 0; i < recv4.size(); i++) begin
            checks++;
            if (recv4[i] !== 32'h100 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL wrap_order[%0d] got %h want %h", i, recv4[i], 32'h100 + 32'(i));
            end
        end
        while (!(idle4 && !ack4) && c < 200) begin @(negedge clk); c++; end
        auto4 = 0;
    endtask

    task automatic test_reset_mid();
        doReset();
        push4(32'hDEAD_BEEF);
        valid4 = 1'b0;
        @(negedge clk);
        ack4 = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 6;
        if (ready4 !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b want 1", ready4); end
        if (req4 !== 1'b0)   begin errors++; $display("[TB] FAIL mid_req got %b want 0", req4); end
        if (data4 !== 32'h0) begin errors++; $display("[TB] FAIL mid_data got %h want 0", data4); end
        if (busy4 !== 1'b0)  begin errors++; $display("[TB] FAIL mid_busy got %b want 0", busy4); end
        if (idle4 !== 1'b1)  begin errors++; $display("[TB] FAIL mid_idle got %b want 1", idle4); end
        if (count4 !== 3'd0) begin errors++; $display("[TB] FAIL mid_count got %0d want 0", count4); end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checks += 3;
        if (req4 !== 1'b0)  begin errors++; $display("[TB] FAIL stale_req got %b want 0", req4); end
        if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL stale_busy got %b want 0", busy4); end
        if (idle4 !== 1'b1) begin errors++; $display("[TB] FAIL stale_idle got %b want 1", idle4); end
        ack4 = 1'b0;
        repeat (5) @(negedge clk);
        push4(32'h0BAD_F00D);
        valid4 = 1'b0;
        @(negedge clk);
        checks += 2;
        if (req4 !== 1'b1)          begin errors++; $display("[TB] FAIL new_req got %b want 1", req4); end
        if (data4 !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL new_data got %h want 0badf00d", data4); end
    endtask

    task automatic feed4();
        logic [31:0] w;
        for (int i = 0; i < 1000; i++) begin
            w = $urandom;
            exp4.push_back(w);
            push4(w);
            if ($urandom_range(3, 0) == 0) begin
                valid4 = 1'b0;
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
        end
        valid4 = 1'b0;
        waitRecv4(1000, 60000);
    endtask

    task automatic feed2();
        logic [31:0] w;
        for (int i = 0; i < 1000; i++) begin
            w = $urandom;
            exp2.push_back(w);
            push2(w);
            if ($urandom_range(3, 0) == 0) begin
                valid2 = 1'b0;
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
        end
        valid2 = 1'b0;
        waitRecv2(1000, 60000);
    endtask

    task automatic test_random();
        doReset();
        maxDly4 = 20; maxDly2 = 20;
        auto4 = 1; auto2 = 1;
        fork
            feed4();
            feed2();
        join
        for (int i = 0; i < recv4.size() && i < exp4.size(); i++) begin
            checks++;
            if (recv4[i] !== exp4[i]) begin
                errors++;
                $display("[TB] FAIL rnd4[%0d] got %h want %h", i, recv4[i], exp4[i]);
            end
        end
        for (int i = 0; i < recv2.size() && i < exp2.size(); i++) begin
            checks++;
            if (recv2[i] !== exp2[i]) begin
                errors++;
                $display("[TB] FAIL rnd2[%0d] got %h want %h", i, recv2[i], exp2[i]);
            end
        end
        auto4 = 0; auto2 = 0;
    endtask

    initial begin
        $display("[TB] starting handshake_src_queue bench");
        test_reset();
        test_four_phase();
        test_fill();
        test_two_phase();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
